// File: rtl/booth_pkg.sv
// Shared types and helpers for the Booth multiplier datapath and its
// downstream dot-product accumulator.
package booth_pkg;

   typedef enum logic {
      IDLE,
      ACCUM
   } state_t;

   localparam int PROD_W = 32;
   localparam int SAT_W  = 128;

   // Low w bits hold the w-bit signed maximum.
   function automatic logic [SAT_W-1:0] sat_max(input int w);
      return (SAT_W'(1) << (w - 1)) - SAT_W'(1);
   endfunction

   function automatic logic [SAT_W-1:0] sat_min(input int w);
      return SAT_W'(1) << (w - 1);
   endfunction

endpackage

// File: rtl/booth_dot_accumulator_if.sv
// Product-in and result-out valid/ready bundle of the dot-product
// accumulator.
interface booth_dot_accumulator_if #(
   parameter int ACC_W = 40,
   parameter int CNT_W = 16
);

   logic                          clear_i;
   logic                          prod_valid_i;
   logic                          prod_ready_o;
   logic [booth_pkg::PROD_W-1:0]  prod_i;
   logic                          prod_last_i;
   logic                          res_valid_o;
   logic                          res_ready_i;
   logic [ACC_W-1:0]              res_data_o;
   logic [CNT_W-1:0]              res_count_o;
   logic                          res_ovf_o;

   modport master (
      output clear_i,
      output prod_valid_i,
      output prod_i,
      output prod_last_i,
      output res_ready_i,
      input  prod_ready_o,
      input  res_valid_o,
      input  res_data_o,
      input  res_count_o,
      input  res_ovf_o
   );

   modport slave (
      input  clear_i,
      input  prod_valid_i,
      input  prod_i,
      input  prod_last_i,
      input  res_ready_i,
      output prod_ready_o,
      output res_valid_o,
      output res_data_o,
      output res_count_o,
      output res_ovf_o
   );

endinterface

// File: rtl/booth_sat_add.sv
// Accumulator + sign-extended product at ACC_W+1 bits, with overflow
// detect and optional clamp to the ACC_W signed range.
module booth_sat_add
   import booth_pkg::*;
#(
   parameter int ACC_W = 40,
   parameter bit SAT   = 1'b1
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic [PROD_W-1:0] prod,
   output logic [ACC_W-1:0]  sum,
   output logic              ovf
);

   logic [ACC_W:0] wide;

   always_comb begin
      wide = {acc[ACC_W-1], acc}
           + {{(ACC_W + 1 - PROD_W){prod[PROD_W-1]}}, prod};
      ovf = wide[ACC_W] ^ wide[ACC_W-1];
      sum = wide[ACC_W-1:0];
      if (SAT && ovf) begin
         sum = wide[ACC_W] ? ACC_W'(sat_min(ACC_W))
                           : ACC_W'(sat_max(ACC_W));
      end
   end

endmodule

// File: rtl/booth_dot_accumulator.sv
// Accumulates Booth products into per-vector dot products and holds each
// result in a registered valid/ready output stage.
module booth_dot_accumulator
   import booth_pkg::*;
#(
   parameter int ACC_W = 40,
   parameter int CNT_W = 16,
   parameter bit SAT   = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   booth_dot_accumulator_if.slave  bus
);

   state_t           state;
   state_t           state_nx;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic             ovf;
   logic             ovf_nx;

   logic [ACC_W-1:0] sum;
   logic             step_ovf;
   logic [CNT_W-1:0] cnt_inc;
   logic             ovf_any;
   logic             ready;
   logic             accept;
   logic             fire;
   logic             load;

   logic             res_valid;
   logic [ACC_W-1:0] res_data;
   logic [CNT_W-1:0] res_count;
   logic             res_ovf;

   booth_sat_add #(
      .ACC_W (ACC_W),
      .SAT   (SAT)
   ) u_add (
      .acc  (acc),
      .prod (bus.prod_i),
      .sum  (sum),
      .ovf  (step_ovf)
   );

   // Ready depends only on clear and the output stage, never on prod_valid.
   assign ready   = ~bus.clear_i & (~res_valid | bus.res_ready_i);
   assign accept  = bus.prod_valid_i & ready;
   assign fire    = res_valid & bus.res_ready_i;
   assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
   assign ovf_any = ovf | step_ovf;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nx;
         acc   <= acc_nx;
         cnt   <= cnt_nx;
         ovf   <= ovf_nx;
      end
   end

   always_comb begin
      state_nx = state;
      acc_nx   = acc;
      cnt_nx   = cnt;
      ovf_nx   = ovf;
      load     = 1'b0;
      if (bus.clear_i) begin
         state_nx = IDLE;
         acc_nx   = '0;
         cnt_nx   = '0;
         ovf_nx   = 1'b0;
      end else if (accept) begin
         unique case (state)
            IDLE: begin
               if (bus.prod_last_i) begin
                  load = 1'b1;
               end else begin
                  state_nx = ACCUM;
                  acc_nx   = sum;
                  cnt_nx   = CNT_W'(1);
                  ovf_nx   = step_ovf;
               end
            end
            ACCUM: begin
               if (bus.prod_last_i) begin
                  load     = 1'b1;
                  state_nx = IDLE;
                  acc_nx   = '0;
                  cnt_nx   = '0;
                  ovf_nx   = 1'b0;
               end else begin
                  acc_nx = sum;
                  cnt_nx = cnt_inc;
                  ovf_nx = ovf_any;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // A load in a fire cycle overwrites the departing result.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         res_count <= '0;
         res_ovf   <= 1'b0;
      end else if (load) begin
         res_valid <= 1'b1;
         res_data  <= sum;
         res_count <= cnt_inc;
         res_ovf   <= ovf_any;
      end else if (fire) begin
         res_valid <= 1'b0;
      end
   end

   assign bus.prod_ready_o = ready;
   assign bus.res_valid_o  = res_valid;
   assign bus.res_data_o   = res_data;
   assign bus.res_count_o  = res_count;
   assign bus.res_ovf_o    = res_ovf;

endmodule

// File: tb/tb_booth_dot_accumulator.sv
// Directed bench: vector table on a 40-bit saturating instance plus
// corner sequences, and 33-bit saturating/wrapping instances.
module tb_booth_dot_accumulator;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   always #5 clk = ~clk;

   booth_dot_accumulator_if #(.ACC_W(40), .CNT_W(16)) ifa ();
   booth_dot_accumulator_if #(.ACC_W(33), .CNT_W(2))  ifs ();
   booth_dot_accumulator_if #(.ACC_W(33), .CNT_W(2))  ifw ();

   // The wrapping instance mirrors the saturating one's stimulus.
   assign ifw.clear_i      = ifs.clear_i;
   assign ifw.prod_valid_i = ifs.prod_valid_i;
   assign ifw.prod_i       = ifs.prod_i;
   assign ifw.prod_last_i  = ifs.prod_last_i;
   assign ifw.res_ready_i  = ifs.res_ready_i;

   booth_dot_accumulator #(
      .ACC_W (40), .CNT_W (16), .SAT (1'b1)
   ) dut_a (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifa.slave)
   );

   booth_dot_accumulator #(
      .ACC_W (33), .CNT_W (2), .SAT (1'b1)
   ) dut_s (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifs.slave)
   );

   booth_dot_accumulator #(
      .ACC_W (33), .CNT_W (2), .SAT (1'b0)
   ) dut_w (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifw.slave)
   );

   typedef struct {
      logic [31:0] prod;
      logic        last;
      logic [39:0] data;
      logic [15:0] count;
      logic        ovf;
   } vec_t;

   vec_t tbl [9];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: prod_ready_o never rose", name);
   endtask

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic send_a(input logic [31:0] p, input logic l);
      int n = 0;
      ifa.prod_valid_i = 1'b1;
      ifa.prod_i       = p;
      ifa.prod_last_i  = l;
      while (!ifa.prod_ready_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) timeout("send_a");
      @(negedge clk);
      ifa.prod_valid_i = 1'b0;
      ifa.prod_last_i  = 1'b0;
   endtask

   task automatic send_s(input logic [31:0] p, input logic l);
      int n = 0;
      ifs.prod_valid_i = 1'b1;
      ifs.prod_i       = p;
      ifs.prod_last_i  = l;
      while (!ifs.prod_ready_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) timeout("send_s");
      @(negedge clk);
      ifs.prod_valid_i = 1'b0;
      ifs.prod_last_i  = 1'b0;
   endtask

   task automatic chk_a(input string name,
                        input logic [39:0] d,
                        input logic [15:0] c,
                        input logic o);
      chk({name, "_valid"}, 64'(ifa.res_valid_o), 64'(1'b1));
      chk({name, "_data"},  64'(ifa.res_data_o),  64'(d));
      chk({name, "_count"}, 64'(ifa.res_count_o), 64'(c));
      chk({name, "_ovf"},   64'(ifa.res_ovf_o),   64'(o));
   endtask

   task automatic chk_sw(input string name,
                         input logic [32:0] ds,
                         input logic [32:0] dw,
                         input logic [1:0]  c,
                         input logic o);
      chk({name, "_s_valid"}, 64'(ifs.res_valid_o), 64'(1'b1));
      chk({name, "_s_data"},  64'(ifs.res_data_o),  64'(ds));
      chk({name, "_s_count"}, 64'(ifs.res_count_o), 64'(c));
      chk({name, "_s_ovf"},   64'(ifs.res_ovf_o),   64'(o));
      chk({name, "_w_valid"}, 64'(ifw.res_valid_o), 64'(1'b1));
      chk({name, "_w_data"},  64'(ifw.res_data_o),  64'(dw));
      chk({name, "_w_count"}, 64'(ifw.res_count_o), 64'(c));
      chk({name, "_w_ovf"},   64'(ifw.res_ovf_o),   64'(o));
   endtask

   initial begin
      tbl[0] = '{32'd6,          1'b0, 40'd0,          16'd0, 1'b0};
      tbl[1] = '{32'hFFFF_FFEC,  1'b0, 40'd0,          16'd0, 1'b0};
      tbl[2] = '{32'd100,        1'b1, 40'd86,         16'd3, 1'b0};
      tbl[3] = '{32'hFFFF_FFFF,  1'b1, 40'hFF_FFFF_FFFF, 16'd1, 1'b0};
      tbl[4] = '{32'd1000,       1'b0, 40'd0,          16'd0, 1'b0};
      tbl[5] = '{32'hFFFF_F448,  1'b1, 40'hFF_FFFF_F830, 16'd2, 1'b0};
      tbl[6] = '{32'h7FFF_FFFF,  1'b1, 40'h00_7FFF_FFFF, 16'd1, 1'b0};
      tbl[7] = '{32'h8000_0000,  1'b0, 40'd0,          16'd0, 1'b0};
      tbl[8] = '{32'h8000_0000,  1'b1, 40'hFF_0000_0000, 16'd2, 1'b0};

      ifa.clear_i = 1'b0;
      ifa.prod_valid_i = 1'b0;
      ifa.prod_i = '0;
      ifa.prod_last_i = 1'b0;
      ifa.res_ready_i = 1'b1;
      ifs.clear_i = 1'b0;
      ifs.prod_valid_i = 1'b0;
      ifs.prod_i = '0;
      ifs.prod_last_i = 1'b0;
      ifs.res_ready_i = 1'b1;

      #2;
      chk("rst_valid", 64'(ifa.res_valid_o), 64'(1'b0));
      chk("rst_data",  64'(ifa.res_data_o),  64'd0);
      chk("rst_count", 64'(ifa.res_count_o), 64'd0);
      chk("rst_ovf",   64'(ifa.res_ovf_o),   64'(1'b0));
      chk("rst_ready", 64'(ifa.prod_ready_o), 64'(1'b1));
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         send_a(tbl[i].prod, tbl[i].last);
         if (tbl[i].last) begin
            chk_a($sformatf("vec%0d", i),
                  tbl[i].data, tbl[i].count, tbl[i].ovf);
         end else begin
            chk($sformatf("vec%0d_valid", i),
                64'(ifa.res_valid_o), 64'(1'b0));
         end
      end
      @(negedge clk);
      chk("drain_valid", 64'(ifa.res_valid_o), 64'(1'b0));

      // Backpressure: pending result blocks the next last element.
      ifa.res_ready_i = 1'b0;
      send_a(32'd10, 1'b1);
      chk_a("bp_first", 40'd10, 16'd1, 1'b0);
      ifa.prod_valid_i = 1'b1;
      ifa.prod_i       = 32'd4;
      ifa.prod_last_i  = 1'b1;
      #1;
      chk("bp_ready0", 64'(ifa.prod_ready_o), 64'(1'b0));
      repeat (3) begin
         @(negedge clk);
         chk("bp_hold_ready", 64'(ifa.prod_ready_o), 64'(1'b0));
         chk_a("bp_hold", 40'd10, 16'd1, 1'b0);
      end
      ifa.res_ready_i = 1'b1;
      #1;
      chk("bp_ready1", 64'(ifa.prod_ready_o), 64'(1'b1));
      @(negedge clk);
      ifa.prod_valid_i = 1'b0;
      ifa.prod_last_i  = 1'b0;
      chk_a("bp_swap", 40'd4, 16'd1, 1'b0);
      @(negedge clk);
      chk("bp_done", 64'(ifa.res_valid_o), 64'(1'b0));

      // Clear mid-vector, with a product offered during the clear.
      send_a(32'd5, 1'b0);
      send_a(32'd5, 1'b0);
      ifa.clear_i      = 1'b1;
      ifa.prod_valid_i = 1'b1;
      ifa.prod_i       = 32'd1000;
      ifa.prod_last_i  = 1'b1;
      #1;
      chk("clr_ready", 64'(ifa.prod_ready_o), 64'(1'b0));
      @(negedge clk);
      ifa.clear_i      = 1'b0;
      ifa.prod_valid_i = 1'b0;
      ifa.prod_last_i  = 1'b0;
      chk("clr_noacc", 64'(ifa.res_valid_o), 64'(1'b0));
      send_a(32'd7, 1'b1);
      chk_a("clr_after", 40'd7, 16'd1, 1'b0);

      // Clear leaves a pending result untouched.
      ifa.res_ready_i = 1'b0;
      ifa.clear_i     = 1'b1;
      @(negedge clk);
      ifa.clear_i = 1'b0;
      chk_a("clr_pend", 40'd7, 16'd1, 1'b0);
      ifa.res_ready_i = 1'b1;
      @(negedge clk);
      chk("clr_pend_fire", 64'(ifa.res_valid_o), 64'(1'b0));

      // Asynchronous reset with a result pending.
      ifa.res_ready_i = 1'b0;
      send_a(32'd50, 1'b1);
      chk_a("rst2_pend", 40'd50, 16'd1, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst2_valid", 64'(ifa.res_valid_o), 64'(1'b0));
      chk("rst2_data",  64'(ifa.res_data_o),  64'd0);
      chk("rst2_count", 64'(ifa.res_count_o), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      ifa.res_ready_i = 1'b1;

      // Reset mid-vector discards the partial sum.
      send_a(32'd5, 1'b0);
      #2;
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      send_a(32'd3, 1'b1);
      chk_a("rst3_after", 40'd3, 16'd1, 1'b0);

      // 33-bit: positive overflow, saturating vs wrapping.
      send_s(32'h7FFF_FFFF, 1'b0);
      send_s(32'h7FFF_FFFF, 1'b0);
      send_s(32'h7FFF_FFFF, 1'b1);
      chk_sw("posovf", 33'h0_FFFF_FFFF, 33'h1_7FFF_FFFD, 2'd3, 1'b1);

      // 33-bit: negative overflow.
      send_s(32'h8000_0000, 1'b0);
      send_s(32'h8000_0000, 1'b0);
      send_s(32'h8000_0000, 1'b1);
      chk_sw("negovf", 33'h1_0000_0000, 33'h0_8000_0000, 2'd3, 1'b1);

      // Element counter saturates at 3 with CNT_W=2.
      for (int i = 0; i < 5; i++) send_s(32'd1, 1'(i == 4));
      chk_sw("cntsat", 33'd5, 33'd5, 2'd3, 1'b0);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
